// File: rtl/dm_uart_rx_pkg.sv
// Shared definitions for the memory-mapped UART receiver.
// Holds the register offsets inside the 3-word window, the STATUS bit
// positions, the DATA valid bit position and the receiver FSM state type.
package dm_uart_rx_pkg;

    localparam int WORD_SIZE = 32;

    localparam logic [31:0] OFF_DATA   = 32'h0000_0000;
    localparam logic [31:0] OFF_STATUS = 32'h0000_0004;
    localparam logic [31:0] OFF_BAUD   = 32'h0000_0008;

    localparam int DATA_VALID_BIT = 31;

    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERRUN   = 2;
    localparam int STAT_FRAME_ERR = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/dm_rx_fifo.sv
// Small synchronous FIFO holding received bytes.
// Ports: clk/rst (sync, active-high), push/din write side, pop read side,
// head = oldest entry (combinational), count/full/empty occupancy.
// A pop and a push in the same cycle both happen; a pop frees the slot
// first, so a full FIFO accepts a simultaneous push.
module dm_rx_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic             do_pop_s;
    logic             do_push_s;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign head      = mem_r[rd_ptr_r];
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count    <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dm_uart_rx.sv
// Memory-mapped 8N1 UART receiver on the core data-memory bus.
// Ports: i_clk/i_rst (sync, active-high); i_rx serial line (idle high);
// i_DM_addr/i_DM_wd/i_DM_wen/i_DM_ren bus request; o_DM_rd combinational
// read data; o_DM_sel high when the address hits DATA, STATUS or BAUD_DIV;
// o_irq registered, high while bytes are queued or an error flag is set.
module dm_uart_rx
    import dm_uart_rx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
    parameter int          CLKS_PER_BIT = 104,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rx,
    input  logic [WORD_SIZE-1:0] i_DM_addr,
    input  logic [WORD_SIZE-1:0] i_DM_wd,
    input  logic [3:0]           i_DM_wen,
    input  logic                 i_DM_ren,
    output logic [WORD_SIZE-1:0] o_DM_rd,
    output logic                 o_DM_sel,
    output logic                 o_irq
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic            rx_meta_r, rx_sync_r, rx_prev_r;
    rx_state_e       state_r;
    logic [15:0]     baud_div_r;
    logic [15:0]     period_m1_r;
    logic [15:0]     cnt_r;
    logic [2:0]      bit_idx_r;
    logic [7:0]      shift_r;
    logic            overrun_r, frame_err_r, irq_r;

    logic [31:0]     offset_s;
    logic            sel_data_s, sel_status_s, sel_baud_s;
    logic            word_wr_s, clr_wr_s, baud_wr_s;
    logic            pop_s, push_s, overflow_s, frame_bad_s;
    logic [16:0]     half_s;
    logic            start_tick_s, bit_tick_s, stop_tick_s;
    logic [7:0]      head_s;
    logic [AW:0]     count_s;
    logic            full_s, empty_s;
    logic [31:0]     rd_s;
    logic            unused_wd_bits_s;

    // Address decode: only the three exact word addresses are claimed.
    assign offset_s     = i_DM_addr - BASE_ADDR;
    assign sel_data_s   = (offset_s == OFF_DATA);
    assign sel_status_s = (offset_s == OFF_STATUS);
    assign sel_baud_s   = (offset_s == OFF_BAUD);
    assign o_DM_sel     = sel_data_s || sel_status_s || sel_baud_s;

    assign word_wr_s    = (i_DM_wen == 4'b1111);
    assign clr_wr_s     = word_wr_s && sel_status_s;
    assign baud_wr_s    = word_wr_s && sel_baud_s;
    assign pop_s        = i_DM_ren && sel_data_s && !empty_s;
    assign unused_wd_bits_s = ^i_DM_wd[31:16];

    // Mid-bit sample points; START waits floor(P/2) with P = period_m1 + 1.
    assign half_s       = ({1'b0, period_m1_r} + 17'd1) >> 1;
    assign start_tick_s = (state_r == ST_START) && (({1'b0, cnt_r} + 17'd1) >= half_s);
    assign bit_tick_s   = (cnt_r == period_m1_r);
    assign stop_tick_s  = (state_r == ST_STOP) && bit_tick_s;
    assign push_s       = stop_tick_s && rx_sync_r;
    assign frame_bad_s  = stop_tick_s && !rx_sync_r;
    assign overflow_s   = push_s && full_s && !pop_s;

    dm_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (shift_r),
        .head  (head_s),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Combinational read mux so the single-cycle core sees data this cycle.
    always_comb begin
        rd_s = 32'd0;
        if (sel_data_s) begin
            if (!empty_s) begin
                rd_s[DATA_VALID_BIT] = 1'b1;
                rd_s[7:0]            = head_s;
            end else begin
                rd_s = 32'd0;
            end
        end else if (sel_status_s) begin
            rd_s[STAT_NOT_EMPTY] = !empty_s;
            rd_s[STAT_FULL]      = full_s;
            rd_s[STAT_OVERRUN]   = overrun_r;
            rd_s[STAT_FRAME_ERR] = frame_err_r;
        end else if (sel_baud_s) begin
            rd_s[15:0] = baud_div_r;
        end else begin
            rd_s = 32'd0;
        end
    end

    assign o_DM_rd = rd_s;
    assign o_irq   = irq_r;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= i_rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Receiver FSM; the bit period is latched at the start edge so BAUD_DIV
    // writes during a frame only apply to the next one.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= ST_IDLE;
            period_m1_r <= 16'(CLKS_PER_BIT - 1);
            cnt_r       <= 16'd0;
            bit_idx_r   <= 3'd0;
            shift_r     <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rx_prev_r && !rx_sync_r) begin
                        state_r     <= ST_START;
                        period_m1_r <= baud_div_r;
                        cnt_r       <= 16'd0;
                    end
                end
                ST_START: begin
                    if (start_tick_s) begin
                        cnt_r     <= 16'd0;
                        bit_idx_r <= 3'd0;
                        // A high line here was a glitch, not a start bit.
                        state_r   <= rx_sync_r ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_tick_s) begin
                        cnt_r   <= 16'd0;
                        shift_r <= {rx_sync_r, shift_r[7:1]};
                        if (bit_idx_r == 3'd7) begin
                            state_r <= ST_STOP;
                        end
                        bit_idx_r <= bit_idx_r + 3'd1;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (bit_tick_s) begin
                        cnt_r   <= 16'd0;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 16'd0;
                end
            endcase
        end
    end

    // Baud divisor, sticky error flags (a new event wins over a W1C clear) and irq.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            baud_div_r  <= 16'(CLKS_PER_BIT - 1);
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
            irq_r       <= 1'b0;
        end else begin
            if (baud_wr_s) begin
                baud_div_r <= i_DM_wd[15:0];
            end
            if (overflow_s) begin
                overrun_r <= 1'b1;
            end else if (clr_wr_s && i_DM_wd[STAT_OVERRUN]) begin
                overrun_r <= 1'b0;
            end
            if (frame_bad_s) begin
                frame_err_r <= 1'b1;
            end else if (clr_wr_s && i_DM_wd[STAT_FRAME_ERR]) begin
                frame_err_r <= 1'b0;
            end
            irq_r <= (count_s != '0) || overrun_r || frame_err_r;
        end
    end

endmodule

// File: tb/tb_dm_uart_rx.sv
// Directed self-checking bench for dm_uart_rx (16 clk/bit, 4-entry FIFO).
module tb_dm_uart_rx;

    localparam logic [31:0] BASE   = 32'h0001_0000;
    localparam logic [31:0] A_DATA = BASE + 32'h0;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_BAUD = BASE + 32'h8;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_rx = 1'b1;
    logic [31:0] i_DM_addr = 32'd0;
    logic [31:0] i_DM_wd = 32'd0;
    logic [3:0]  i_DM_wen = 4'd0;
    logic        i_DM_ren = 1'b0;
    logic [31:0] o_DM_rd;
    logic        o_DM_sel;
    logic        o_irq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dm_uart_rx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (16),
        .FIFO_DEPTH   (4)
    ) dut (
        .i_clk     (clk),
        .i_rst     (i_rst),
        .i_rx      (i_rx),
        .i_DM_addr (i_DM_addr),
        .i_DM_wd   (i_DM_wd),
        .i_DM_wen  (i_DM_wen),
        .i_DM_ren  (i_DM_ren),
        .o_DM_rd   (o_DM_rd),
        .o_DM_sel  (o_DM_sel),
        .o_irq     (o_irq)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        i_DM_addr = addr;
        i_DM_ren  = 1'b1;
        #1;
        data = o_DM_rd;
        tick();
        i_DM_ren  = 1'b0;
        i_DM_addr = 32'd0;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] wen);
        i_DM_addr = addr;
        i_DM_wd   = wd;
        i_DM_wen  = wen;
        tick();
        i_DM_wen  = 4'd0;
        i_DM_addr = 32'd0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input int p);
        i_rx = 1'b0;
        repeat (p) tick();
        for (int i = 0; i < 8; i++) begin
            i_rx = b[i];
            repeat (p) tick();
        end
        i_rx = stop;
        repeat (p) tick();
        i_rx = 1'b1;
        repeat (2) tick();
    endtask

    logic [31:0] d;

    initial begin
        repeat (3) tick();
        i_rst = 1'b0;
        tick();

        // Reset state and decode
        bus_read(A_STAT, d);  check_eq("reset_status", d, 32'h0);
        bus_read(A_DATA, d);  check_eq("reset_data", d, 32'h0);
        bus_read(A_BAUD, d);  check_eq("reset_baud", d, 32'd15);
        check_eq("reset_irq", {31'd0, o_irq}, 32'd0);
        i_DM_addr = BASE + 32'hC; #1;
        check_eq("out_of_window_sel", {31'd0, o_DM_sel}, 32'd0);
        check_eq("out_of_window_rd", o_DM_rd, 32'd0);
        i_DM_addr = A_STAT; #1;
        check_eq("status_sel", {31'd0, o_DM_sel}, 32'd1);
        i_DM_addr = 32'd0;
        tick();

        // Single byte
        send_byte(8'hA5, 1'b1, 16);
        bus_read(A_STAT, d);  check_eq("a5_status", d, 32'h1);
        check_eq("a5_irq", {31'd0, o_irq}, 32'd1);
        bus_read(A_DATA, d);  check_eq("a5_data", d, 32'h8000_00A5);
        bus_read(A_DATA, d);  check_eq("a5_second_read", d, 32'h0);
        tick();
        check_eq("a5_irq_clear", {31'd0, o_irq}, 32'd0);

        // Overrun: five bytes into a four-entry FIFO
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, 16);
        bus_read(A_STAT, d);  check_eq("ovr_status", d, 32'h7);
        for (int i = 1; i <= 4; i++) begin
            bus_read(A_DATA, d);
            check_eq("ovr_data", d, 32'h8000_0000 | 32'(i));
        end
        bus_read(A_STAT, d);  check_eq("ovr_status_drained", d, 32'h4);
        bus_write(A_STAT, 32'h4, 4'b0011);
        bus_read(A_STAT, d);  check_eq("ovr_partial_write", d, 32'h4);
        bus_write(A_STAT, 32'h4, 4'b1111);
        bus_read(A_STAT, d);  check_eq("ovr_cleared", d, 32'h0);

        // Framing error
        send_byte(8'h55, 1'b0, 16);
        repeat (4) tick();
        bus_read(A_STAT, d);  check_eq("ferr_status", d, 32'h8);
        check_eq("ferr_irq", {31'd0, o_irq}, 32'd1);
        bus_write(A_STAT, 32'h8, 4'b1111);
        bus_read(A_STAT, d);  check_eq("ferr_cleared", d, 32'h0);

        // Start-bit glitch
        i_rx = 1'b0;
        repeat (3) tick();
        i_rx = 1'b1;
        repeat (40) tick();
        bus_read(A_STAT, d);  check_eq("glitch_status", d, 32'h0);
        check_eq("glitch_irq", {31'd0, o_irq}, 32'd0);
        send_byte(8'h5A, 1'b1, 16);
        bus_read(A_DATA, d);  check_eq("after_glitch_data", d, 32'h8000_005A);

        // Baud divisor change, upper bits read back zero
        bus_write(A_BAUD, 32'hFFFF_0007, 4'b1111);
        bus_read(A_BAUD, d);  check_eq("baud_readback", d, 32'h7);
        send_byte(8'h3C, 1'b1, 8);
        bus_read(A_DATA, d);  check_eq("baud8_data", d, 32'h8000_003C);
        fork
            send_byte(8'hC3, 1'b1, 8);
            begin
                repeat (30) tick();
                bus_write(A_BAUD, 32'd15, 4'b1111);
            end
        join
        bus_read(A_DATA, d);  check_eq("midframe_baud_data", d, 32'h8000_00C3);

        // Full FIFO with a pop on the stop-sample cycle
        for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i), 1'b1, 16);
        bus_read(A_STAT, d);  check_eq("full_status", d, 32'h3);
        fork
            send_byte(8'h15, 1'b1, 16);
            begin
                repeat (154) tick();
                bus_read(A_DATA, d);
                check_eq("race_pop_data", d, 32'h8000_0011);
            end
        join
        bus_read(A_STAT, d);  check_eq("race_status", d, 32'h3);
        for (int i = 0; i < 4; i++) begin
            bus_read(A_DATA, d);
            check_eq("race_order", d, 32'h8000_0012 + 32'(i));
        end

        // Reset mid-frame
        send_byte(8'h77, 1'b1, 16);
        bus_write(A_BAUD, 32'd9, 4'b1111);
        i_rx = 1'b0;
        repeat (40) tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        i_rx  = 1'b1;
        bus_read(A_STAT, d);  check_eq("rst_status", d, 32'h0);
        bus_read(A_BAUD, d);  check_eq("rst_baud", d, 32'd15);
        check_eq("rst_irq", {31'd0, o_irq}, 32'd0);
        repeat (200) tick();
        bus_read(A_STAT, d);  check_eq("rst_no_push", d, 32'h0);
        bus_read(A_DATA, d);  check_eq("rst_data", d, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
